// File: rtl/cic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cic_ctrl_pkg
// Shared types and constants for the CIC decimator reconfiguration sequencer.
//   ctrl_state_t   : sequencer states (IDLE, RUN, DRAIN, FLUSH, SETTLE)
//   decim_sel_t    : 3-bit decimation-ratio select, D = 2**sel
//   sel2d()        : converts a select into the 8-bit ratio D
//   MAX_SEL_DEF    : default highest legal select
//   SETTLE_OUT_DEF : default number of outputs discarded after a reload
//   CNT_W          : width of the shared sequencing counter
// -----------------------------------------------------------------------------
package cic_ctrl_pkg;

    localparam int MAX_SEL_DEF    = 4;
    localparam int SETTLE_OUT_DEF = 8;
    localparam int CNT_W          = 13;

    typedef logic [2:0] decim_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_SETTLE = 3'd4
    } ctrl_state_t;

    function automatic logic [7:0] sel2d(input decim_sel_t sel);
        return 8'd1 << sel;
    endfunction

endpackage

// File: rtl/cic_ctrl_timer.sv
// -----------------------------------------------------------------------------
// cic_ctrl_timer
// Loadable down-counter that saturates at zero. One instance is shared by the
// DRAIN, FLUSH and SETTLE phases of the sequencer.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset (count -> 0)
//   load     in  load load_val this cycle (wins over dec)
//   load_val in  W-bit reload value
//   dec      in  decrement by one unless already zero
//   zero     out count is zero
// -----------------------------------------------------------------------------
module cic_ctrl_timer
    import cic_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cic_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// cic_reconfig_ctrl
// Run-time sequencer for the CIC decimator + compensator stage. Ratio and
// compensator changes are applied glitch-free: drain the pipeline, flush it,
// reload the new settings, then discard outputs until the filter has settled.
//
// Optional feature macro: CIC_CTRL_TIMEOUT_EN
//   defined   : a watchdog ends SETTLE after TIMEOUT_CYC cycles with ack+err
//   undefined : SETTLE waits for SETTLE_OUT outputs indefinitely
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_req           request level, held until cfg_ack
//   cfg_enable        requested stage enable
//   cfg_comp_en       requested compensator enable
//   cfg_decim_sel     requested ratio select
//   cfg_ack, cfg_err  one-cycle completion / rejection pulses
//   busy              high in DRAIN, FLUSH and SETTLE
//   x_valid_i/o       upstream valid and its gated copy into the datapath
//   y_valid_i/o       datapath output valid and its masked copy downstream
//   dp_enable         datapath enable
//   dp_comp_enable    datapath compensator enable
//   dp_decim_sel      datapath ratio select
//   dp_flush          synchronous clear of datapath state
//   D_active          current ratio 2**dp_decim_sel
// -----------------------------------------------------------------------------
module cic_reconfig_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int MAX_SEL    = MAX_SEL_DEF,
    parameter int DRAIN_CYC  = 32,
    parameter int FLUSH_CYC  = 4,
    parameter int SETTLE_OUT = SETTLE_OUT_DEF
`ifdef CIC_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_req,
    input  logic       cfg_enable,
    input  logic       cfg_comp_en,
    input  logic [2:0] cfg_decim_sel,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       busy,
    input  logic       x_valid_i,
    output logic       x_valid_o,
    input  logic       y_valid_i,
    output logic       y_valid_o,
    output logic       dp_enable,
    output logic       dp_comp_enable,
    output logic [2:0] dp_decim_sel,
    output logic       dp_flush,
    output logic [7:0] D_active
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_RUN    = ST_RUN;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;
    localparam logic [2:0] S_FLUSH  = ST_FLUSH;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;

    localparam decim_sel_t       MAX_SEL_V = decim_sel_t'(MAX_SEL);
    // Reload values are "cycles - 1" so a phase lasts exactly N cycles:
    // the exit is taken in the cycle where the counter reads zero.
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_OUT - 1);

    logic [2:0]       st, nxt;
    logic             armed;
    logic             en_q, comp_q;
    decim_sel_t       sel_q;
    logic             ack_q, err_q;
    logic             accept, illegal, enter_flush;
    logic             fin_ack, fin_err;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_ld_val;
    logic             wd_zero;

    // A request is taken once per cfg_req high period, and only when the
    // datapath is not in the middle of a reconfiguration.
    assign accept      = cfg_req && armed && ((st == S_IDLE) || (st == S_RUN));
    assign illegal     = (cfg_decim_sel > MAX_SEL_V);
    assign enter_flush = (nxt == S_FLUSH) && (st != S_FLUSH);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        nxt     = st;
        fin_ack = 1'b0;
        fin_err = 1'b0;
        case (st)
            S_IDLE:   if (accept && !illegal) nxt = S_FLUSH;
            S_RUN:    if (accept && !illegal) nxt = S_DRAIN;
            S_DRAIN:  if (tmr_zero) nxt = S_FLUSH;
            S_FLUSH: begin
                if (tmr_zero) begin
                    if (en_q) begin
                        nxt = S_SETTLE;
                    end else begin
                        nxt     = S_IDLE;
                        fin_ack = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                // Counter reaching zero means SETTLE_OUT-1 outputs were
                // already discarded; this pulse is the last one.
                if (y_valid_i && tmr_zero) begin
                    nxt     = S_RUN;
                    fin_ack = 1'b1;
                end else if (wd_zero) begin
                    nxt     = S_RUN;
                    fin_ack = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default:  nxt = S_IDLE;
        endcase
    end

    // Shared phase counter: reloaded on every state entry.
    always_comb begin
        tmr_ld_val = '0;
        case (nxt)
            S_DRAIN:  tmr_ld_val = DRAIN_LD;
            S_FLUSH:  tmr_ld_val = FLUSH_LD;
            S_SETTLE: tmr_ld_val = SETTLE_LD;
            default:  tmr_ld_val = '0;
        endcase
    end

    assign tmr_load = (nxt != st);
    assign tmr_dec  = (st == S_DRAIN) || (st == S_FLUSH) || ((st == S_SETTLE) && y_valid_i);

    cic_ctrl_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef CIC_CTRL_TIMEOUT_EN
    // SETTLE watchdog: counts every cycle spent in SETTLE.
    cic_ctrl_timer #(.W(CNT_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load     ((nxt == S_SETTLE) && (st != S_SETTLE)),
        .load_val (CNT_W'(TIMEOUT_CYC - 1)),
        .dec      (st == S_SETTLE),
        .zero     (wd_zero)
    );
`else
    assign wd_zero = 1'b0;
`endif

    // NOTE: only control registers are reset here; there is no storage array,
    // so every flop returns to a defined value on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_IDLE;
            armed  <= 1'b1;
            en_q   <= 1'b0;
            comp_q <= 1'b0;
            sel_q  <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st    <= nxt;
            ack_q <= fin_ack | (accept & illegal);
            err_q <= fin_err | (accept & illegal);
            if (accept) begin
                armed <= 1'b0;
            end else if (!cfg_req) begin
                armed <= 1'b1;
            end
            // New settings reach the datapath only while it is disabled.
            if (enter_flush) begin
                en_q   <= cfg_enable;
                comp_q <= cfg_comp_en;
                sel_q  <= cfg_decim_sel;
            end
        end
    end

    assign cfg_ack        = ack_q;
    assign cfg_err        = err_q;
    assign busy           = (st == S_DRAIN) || (st == S_FLUSH) || (st == S_SETTLE);
    assign dp_enable      = (st == S_RUN) || (st == S_DRAIN) || (st == S_SETTLE);
    assign dp_flush       = (st == S_FLUSH);
    assign dp_comp_enable = comp_q;
    assign dp_decim_sel   = sel_q;
    assign D_active       = sel2d(sel_q);
    assign x_valid_o      = x_valid_i && ((st == S_RUN) || (st == S_SETTLE));
    assign y_valid_o      = y_valid_i && (st == S_RUN);

endmodule

// File: tb/tb_cic_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_reconfig_ctrl
// Directed bench for cic_reconfig_ctrl: table-driven valid-gating vectors in
// IDLE and RUN, plus hand-written reconfiguration sequences (IDLE reload,
// RUN reload, illegal select, reset mid-drain, disable, optional watchdog).
// -----------------------------------------------------------------------------
module tb_cic_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req, cfg_enable, cfg_comp_en;
    logic [2:0] cfg_decim_sel;
    logic       cfg_ack, cfg_err, busy;
    logic       x_valid_i, x_valid_o, y_valid_i, y_valid_o;
    logic       dp_enable, dp_comp_enable, dp_flush;
    logic [2:0] dp_decim_sel;
    logic [7:0] D_active;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int sel_viol = 0;
    logic [2:0] prev_sel = 3'd0;

    typedef struct {
        logic xi;
        logic yi;
        logic exo;
        logic eyo;
        logic een;
    } vec_t;

    vec_t idle_v[4];
    vec_t run_v[4];

    always #5 clk = ~clk;

    cic_reconfig_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_req        (cfg_req),
        .cfg_enable     (cfg_enable),
        .cfg_comp_en    (cfg_comp_en),
        .cfg_decim_sel  (cfg_decim_sel),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .busy           (busy),
        .x_valid_i      (x_valid_i),
        .x_valid_o      (x_valid_o),
        .y_valid_i      (y_valid_i),
        .y_valid_o      (y_valid_o),
        .dp_enable      (dp_enable),
        .dp_comp_enable (dp_comp_enable),
        .dp_decim_sel   (dp_decim_sel),
        .dp_flush       (dp_flush),
        .D_active       (D_active)
    );

    // Background monitors: ack pulse count and select changes while enabled.
    always @(negedge clk) begin
        if (cfg_ack === 1'b1) ack_cnt <= ack_cnt + 1;
        if (dp_enable === 1'b1 && dp_decim_sel !== prev_sel) sel_viol <= sel_viol + 1;
        prev_sel <= dp_decim_sel;
    end

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts DRAIN cycles; also flags any DRAIN cycle leaking x_valid.
    task automatic drain_phase(input string name, input int exp_n);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        x_valid_i = 1'b1;
        while (busy === 1'b1 && dp_flush === 1'b0 && n < 64) begin
            #1;
            if (x_valid_o !== 1'b0 || dp_enable !== 1'b1) bad++;
            n++;
            tick();
        end
        x_valid_i = 1'b0;
        check({name, "_drain_len"}, n, exp_n);
        check({name, "_drain_gate"}, bad, 0);
    endtask

    task automatic flush_phase(input string name, input int exp_n);
        int n;
        n = 0;
        while (dp_flush === 1'b1 && n < 64) begin
            if (dp_enable !== 1'b0) n += 100;
            n++;
            tick();
        end
        check({name, "_flush_len"}, n, exp_n);
    endtask

    // Eight y_valid_i pulses with gaps; all masked, ack follows the last.
    task automatic settle_phase(input string name, input int exp_d);
        int bad;
        bad = 0;
        check({name, "_settle_en"}, {busy, dp_enable, dp_flush}, 3'b110);
        x_valid_i = 1'b1;
        #1;
        check({name, "_settle_xpass"}, x_valid_o, 1);
        x_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                y_valid_i = 1'b0;
                tick();
            end
            y_valid_i = 1'b1;
            #1;
            if (y_valid_o !== 1'b0 || cfg_ack !== 1'b0) bad++;
            tick();
        end
        y_valid_i = 1'b0;
        check({name, "_settle_mask"}, bad, 0);
        check({name, "_ack"}, {cfg_ack, cfg_err, busy}, 3'b100);
        check({name, "_D_active"}, D_active, exp_d);
        cfg_req = 1'b0;
        y_valid_i = 1'b1;
        #1;
        check({name, "_ypass_after"}, y_valid_o, 1);
        y_valid_i = 1'b0;
        tick();
        check({name, "_ack_one_cycle"}, cfg_ack, 0);
    endtask

    initial begin
        int n;

        idle_v[0] = '{xi: 1'b0, yi: 1'b0, exo: 1'b0, eyo: 1'b0, een: 1'b0};
        idle_v[1] = '{xi: 1'b1, yi: 1'b0, exo: 1'b0, eyo: 1'b0, een: 1'b0};
        idle_v[2] = '{xi: 1'b0, yi: 1'b1, exo: 1'b0, eyo: 1'b0, een: 1'b0};
        idle_v[3] = '{xi: 1'b1, yi: 1'b1, exo: 1'b0, eyo: 1'b0, een: 1'b0};
        run_v[0]  = '{xi: 1'b0, yi: 1'b0, exo: 1'b0, eyo: 1'b0, een: 1'b1};
        run_v[1]  = '{xi: 1'b1, yi: 1'b0, exo: 1'b1, eyo: 1'b0, een: 1'b1};
        run_v[2]  = '{xi: 1'b0, yi: 1'b1, exo: 1'b0, eyo: 1'b1, een: 1'b1};
        run_v[3]  = '{xi: 1'b1, yi: 1'b1, exo: 1'b1, eyo: 1'b1, een: 1'b1};

        rst = 1'b1;
        cfg_req = 1'b0; cfg_enable = 1'b0; cfg_comp_en = 1'b0; cfg_decim_sel = 3'd0;
        x_valid_i = 1'b0; y_valid_i = 1'b0;

        // 1. Reset values
        repeat (2) @(negedge clk);
        x_valid_i = 1'b1; y_valid_i = 1'b1;
        #1;
        check("rst_dp", {dp_enable, dp_flush, dp_comp_enable, dp_decim_sel}, 6'b0);
        check("rst_D_active", D_active, 1);
        check("rst_status", {cfg_ack, cfg_err, busy}, 3'b000);
        check("rst_valids", {x_valid_o, y_valid_o}, 2'b00);
        x_valid_i = 1'b0; y_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            x_valid_i = idle_v[i].xi;
            y_valid_i = idle_v[i].yi;
            #1;
            check($sformatf("idle_vec%0d", i), {x_valid_o, y_valid_o, dp_enable},
                  {idle_v[i].exo, idle_v[i].eyo, idle_v[i].een});
            tick();
        end
        x_valid_i = 1'b0; y_valid_i = 1'b0;
        repeat (3) tick();
        check("idle_no_ack", ack_cnt, 0);

        // 2. IDLE -> FLUSH -> SETTLE -> RUN, sel=1 comp=1
        cfg_req = 1'b1; cfg_enable = 1'b1; cfg_comp_en = 1'b1; cfg_decim_sel = 3'd1;
        tick();
        check("t2_flush_cfg", {dp_flush, dp_enable, busy, dp_comp_enable, dp_decim_sel}, 7'b1011_001);
        check("t2_flush_D", D_active, 2);
        flush_phase("t2", 4);
        settle_phase("t2", 2);

        for (int i = 0; i < 4; i++) begin
            x_valid_i = run_v[i].xi;
            y_valid_i = run_v[i].yi;
            #1;
            check($sformatf("run_vec%0d", i), {x_valid_o, y_valid_o, dp_enable},
                  {run_v[i].exo, run_v[i].eyo, run_v[i].een});
            tick();
        end
        x_valid_i = 1'b0; y_valid_i = 1'b0;

        // 3. RUN -> DRAIN -> FLUSH -> SETTLE -> RUN, sel=3 comp=0
        cfg_req = 1'b1; cfg_enable = 1'b1; cfg_comp_en = 1'b0; cfg_decim_sel = 3'd3;
        y_valid_i = 1'b1;
        #1;
        check("t3_edge_ypass", y_valid_o, 1);
        tick();
        y_valid_i = 1'b0;
        drain_phase("t3", 32);
        check("t3_flush_cfg", {dp_flush, dp_comp_enable, dp_decim_sel}, 5'b10_011);
        check("t3_flush_D", D_active, 8);
        flush_phase("t3", 4);
        settle_phase("t3", 8);

        // 4. Illegal select: rejected, nothing changes
        n = ack_cnt;
        cfg_req = 1'b1; cfg_decim_sel = 3'd6;
        tick();
        check("t4_ack_err", {cfg_ack, cfg_err, busy}, 3'b110);
        check("t4_unchanged", {D_active, dp_decim_sel, dp_enable}, {8'd8, 3'd3, 1'b1});
        cfg_req = 1'b0;
        y_valid_i = 1'b1;
        #1;
        check("t4_still_run", y_valid_o, 1);
        y_valid_i = 1'b0;
        tick();
        check("t4_single_ack", ack_cnt - n, 1);

        // 5. Reset mid-DRAIN; held request serviced again from FLUSH
        cfg_req = 1'b1; cfg_enable = 1'b1; cfg_comp_en = 1'b1; cfg_decim_sel = 3'd2;
        tick();
        repeat (10) tick();
        check("t5_in_drain", {busy, dp_flush, dp_enable}, 3'b101);
        n = ack_cnt;
        rst = 1'b1;
        #1;
        check("t5_rst_dp", {dp_enable, dp_flush, dp_comp_enable, dp_decim_sel, busy}, 7'b0);
        check("t5_rst_D", D_active, 1);
        tick();
        tick();
        check("t5_no_ack", ack_cnt - n, 0);
        rst = 1'b0;
        tick();
        check("t5_reflush", {dp_flush, dp_decim_sel}, 4'b1_010);
        check("t5_reflush_D", D_active, 4);
        flush_phase("t5", 4);
        settle_phase("t5", 4);

        // Disable: RUN -> DRAIN -> FLUSH -> IDLE with ack
        cfg_req = 1'b1; cfg_enable = 1'b0; cfg_comp_en = 1'b0; cfg_decim_sel = 3'd0;
        tick();
        drain_phase("dis", 32);
        flush_phase("dis", 4);
        check("dis_idle", {cfg_ack, cfg_err, busy, dp_enable}, 4'b1000);
        check("dis_D", D_active, 1);
        cfg_req = 1'b0;
        x_valid_i = 1'b1; y_valid_i = 1'b1;
        #1;
        check("dis_gated", {x_valid_o, y_valid_o}, 2'b00);
        x_valid_i = 1'b0; y_valid_i = 1'b0;
        tick();

`ifdef CIC_CTRL_TIMEOUT_EN
        // 6. SETTLE watchdog with no datapath outputs
        cfg_req = 1'b1; cfg_enable = 1'b1; cfg_decim_sel = 3'd1;
        tick();
        flush_phase("t6", 4);
        n = 0;
        while (cfg_ack !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("t6_timeout_len", n, 4096);
        check("t6_ack_err", {cfg_ack, cfg_err, busy, dp_enable}, 4'b1101);
        cfg_req = 1'b0;
        y_valid_i = 1'b1;
        #1;
        check("t6_run", y_valid_o, 1);
        y_valid_i = 1'b0;
        tick();
`endif

        check("sel_stable_while_enabled", sel_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
